// File: rtl/hilo_div.sv
// HI/LO register owner plus a 32-step restoring divider for DIV/DIVU.
// The divider only reports {remainder, quotient}; HI/LO change solely through the writeback port.
module hilo_div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_hilo_en,
    input  logic [DATA_W-1:0]   wb_hi,
    input  logic [DATA_W-1:0]   wb_lo,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    input  logic                div_start,
    input  logic                div_signed,
    input  logic [DATA_W-1:0]   div_opdata1,
    input  logic [DATA_W-1:0]   div_opdata2,
    input  logic                div_annul,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_ready,
    output logic                stall_req
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } div_state_t;

    div_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] dvd, dvd_d;        // dividend magnitude, consumed MSB first
    logic [DATA_W-1:0] dvs, dvs_d;        // divisor magnitude
    logic [DATA_W-1:0] part_rem, part_rem_d;
    logic [DATA_W-1:0] quo, quo_d;
    logic              neg_q, neg_q_d;
    logic              neg_r, neg_r_d;
    logic [2*DATA_W-1:0] result_d;
    logic              ready_d;

    // HI/LO architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (wb_hilo_en) begin
            hi_o <= wb_hi;
            lo_o <= wb_lo;
        end
    end

    // Operand magnitudes and sign bookkeeping at capture
    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_mag, op2_mag;

    always_comb begin
        op1_neg = div_signed & div_opdata1[DATA_W-1];
        op2_neg = div_signed & div_opdata2[DATA_W-1];
        op1_mag = op1_neg ? ('0 - div_opdata1) : div_opdata1;
        op2_mag = op2_neg ? ('0 - div_opdata2) : div_opdata2;
    end

    // One restoring step: the shifted remainder is one bit wider than the divisor.
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W-1:0] rem_diff;
    logic              step_ok;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] q_final;
    logic [DATA_W-1:0] r_final;

    always_comb begin
        rem_shift = {part_rem, dvd[DATA_W-1]};
        step_ok   = (rem_shift >= {1'b0, dvs});
        rem_diff  = rem_shift[DATA_W-1:0] - dvs;
        rem_next  = step_ok ? rem_diff : rem_shift[DATA_W-1:0];
        quo_next  = {quo[DATA_W-2:0], step_ok};
        q_final   = neg_q ? ('0 - quo_next) : quo_next;
        r_final   = neg_r ? ('0 - rem_next) : rem_next;
    end

    // Handshake: div_start is held by EX until it sees div_ready; div_ready and
    // div_result stay valid while div_start remains high, and dropping div_start
    // in S_END returns to S_IDLE with both cleared on the next edge.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        dvd_d      = dvd;
        dvs_d      = dvs;
        part_rem_d = part_rem;
        quo_d      = quo;
        neg_q_d    = neg_q;
        neg_r_d    = neg_r;
        result_d   = div_result;
        ready_d    = div_ready;

        case (state)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (div_start && !div_annul) begin
                    if (div_opdata2 == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        part_rem_d = '0;
                        quo_d      = '0;
                        dvd_d      = op1_mag;
                        dvs_d      = op2_mag;
                        neg_q_d    = op1_neg ^ op2_neg;
                        neg_r_d    = op1_neg;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            S_ON: begin
                if (div_annul || !div_start) begin
                    state_d = S_IDLE;
                end else begin
                    part_rem_d = rem_next;
                    quo_d      = quo_next;
                    dvd_d      = {dvd[DATA_W-2:0], 1'b0};
                    cnt_d      = cnt + 1'b1;
                    // Sign fix-up is folded into the final step so the result is valid on entering S_END
                    if (cnt == LAST_STEP) begin
                        state_d  = S_END;
                        result_d = {r_final, q_final};
                        ready_d  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (!div_start) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            part_rem   <= '0;
            quo        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_result <= '0;
            div_ready  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            dvd        <= dvd_d;
            dvs        <= dvs_d;
            part_rem   <= part_rem_d;
            quo        <= quo_d;
            neg_q      <= neg_q_d;
            neg_r      <= neg_r_d;
            div_result <= result_d;
            div_ready  <= ready_d;
        end
    end

    assign stall_req = ~rst & div_start & ~div_annul & (state != S_END);

endmodule

// File: tb/tb_hilo_div.sv
// Randomized bench for hilo_div: HI/LO writes tracked by a shadow model, divides
// checked against plain-arithmetic quotient/remainder, latency and stall window.
module tb_hilo_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_hilo_en = 1'b0;
    logic [31:0] wb_hi = '0;
    logic [31:0] wb_lo = '0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] div_opdata1 = '0;
    logic [31:0] div_opdata2 = '0;
    logic        div_annul = 1'b0;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall_req;

    hilo_div #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_hilo_en  (wb_hilo_en),
        .wb_hi       (wb_hi),
        .wb_lo       (wb_lo),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_opdata1 (div_opdata1),
        .div_opdata2 (div_opdata2),
        .div_annul   (div_annul),
        .div_result  (div_result),
        .div_ready   (div_ready),
        .stall_req   (stall_req)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    bit          wb_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference: truncating division, remainder takes the dividend's sign
    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // driver: advance one clock, update HI/LO shadow, then drive fresh writeback traffic
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            mdl_hi = '0;
            mdl_lo = '0;
        end else if (wb_hilo_en) begin
            mdl_hi = wb_hi;
            mdl_lo = wb_lo;
        end
        #1;
        if (wb_rand) begin
            wb_hilo_en = ($urandom_range(0, 3) == 0);
            wb_hi = $urandom;
            wb_lo = $urandom;
        end else begin
            wb_hilo_en = 1'b0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check("hilo", {hi_o, lo_o}, {mdl_hi, mdl_lo});
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int bad_stall;
        int exp_lat;
        bit seen;
        logic [63:0] exp;
        exp_q.push_back(model_div(sgn, a, b));
        cycle();
        div_start = 1'b1;
        div_signed = sgn;
        div_opdata1 = a;
        div_opdata2 = b;
        at_neg();
        check("stall_c0", 64'(stall_req), 64'd1);
        lat = 0;
        bad_stall = 0;
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            cycle();
            if (c == 3) begin
                div_opdata1 = $urandom;
                div_opdata2 = $urandom;
                div_signed = ~sgn;
            end
            at_neg();
            if (div_ready) begin
                seen = 1'b1;
                lat = c;
                if (stall_req) bad_stall++;
            end else if (!stall_req) begin
                bad_stall++;
            end
        end
        exp_lat = (b == 32'd0) ? 2 : 33;
        exp = exp_q.pop_front();
        check("latency", 64'(lat), 64'(exp_lat));
        check("stall_window", 64'(bad_stall), 64'd0);
        check("result", div_result, exp);
        cycle();
        div_start = 1'b0;
        at_neg();
        check("ready_hold", 64'(div_ready), 64'd1);
        check("result_hold", div_result, exp);
        cycle();
        at_neg();
        check("ready_clr", 64'(div_ready), 64'd0);
        check("result_clr", div_result, 64'd0);
    endtask

    initial begin
        int bad_ready;
        int bad_stall;
        logic        sgn;
        logic [31:0] a, b;

        // reset state
        #2 rst = 1'b1;
        repeat (3) cycle();
        at_neg();
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_result", div_result, 64'd0);
        check("rst_ready", 64'(div_ready), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        cycle();
        rst = 1'b0;

        // HI/LO write and hold
        cycle();
        wb_hilo_en = 1'b1;
        wb_hi = 32'h12345678;
        wb_lo = 32'h9ABCDEF0;
        at_neg();
        cycle();
        at_neg();
        check("hi_write", 64'(hi_o), 64'h12345678);
        check("lo_write", 64'(lo_o), 64'h9ABCDEF0);
        repeat (3) cycle();
        at_neg();
        check("hi_hold", 64'(hi_o), 64'h12345678);

        // directed divides
        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'h80000000, 32'd1);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE);

        // annul at step 10, then annul held together with start: no divide may run
        cycle();
        div_start = 1'b1;
        div_signed = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        at_neg();
        repeat (10) begin
            cycle();
            at_neg();
        end
        cycle();
        div_annul = 1'b1;
        at_neg();
        check("annul_stall", 64'(stall_req), 64'd0);
        bad_ready = 0;
        bad_stall = 0;
        repeat (40) begin
            cycle();
            at_neg();
            if (div_ready) bad_ready++;
            if (stall_req) bad_stall++;
        end
        check("annul_no_ready", 64'(bad_ready), 64'd0);
        check("annul_no_stall", 64'(bad_stall), 64'd0);
        cycle();
        div_annul = 1'b0;
        div_start = 1'b0;
        at_neg();
        run_div(1'b0, 32'd50, 32'd5);

        // randomized divides with concurrent HI/LO writeback traffic
        wb_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(sgn, a, b);
        end
        wb_rand = 1'b0;

        // asynchronous reset mid-divide with HI/LO nonzero
        cycle();
        wb_hilo_en = 1'b1;
        wb_hi = 32'hCAFEF00D;
        wb_lo = 32'h0BADBEEF;
        cycle();
        div_start = 1'b1;
        div_signed = 1'b0;
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd3;
        at_neg();
        repeat (20) begin
            cycle();
            at_neg();
        end
        check("pre_rst_stall", 64'(stall_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        mdl_hi = '0;
        mdl_lo = '0;
        check("arst_hi", 64'(hi_o), 64'd0);
        check("arst_lo", 64'(lo_o), 64'd0);
        check("arst_result", div_result, 64'd0);
        check("arst_ready", 64'(div_ready), 64'd0);
        check("arst_stall", 64'(stall_req), 64'd0);
        cycle();
        div_start = 1'b0;
        cycle();
        rst = 1'b0;
        at_neg();
        check("post_rst_ready", 64'(div_ready), 64'd0);
        run_div(1'b0, 32'd1000, 32'd3);
        run_div(1'b1, 32'hFFFFFC18, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
